// File: rtl/vending_pkg.sv
// Shared types and helpers for the vending change controller.
package vending_pkg;

  // Controller states; IDLE always holds zero credit, COLLECT holds a partial credit.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } vend_state_e;

  // Coin codes as delivered by the coin-acceptor decoder.
  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_1    = 2'b01;
  localparam logic [1:0] COIN_2    = 2'b10;
  localparam logic [1:0] COIN_3    = 2'b11;

  // Credit value of a coin code, given the three configured denominations.
  function automatic int unsigned coin_value(input logic [1:0] code,
                                             input int unsigned v1,
                                             input int unsigned v2,
                                             input int unsigned v3);
    int unsigned val;
    case (code)
      COIN_1:  val = v1;
      COIN_2:  val = v2;
      COIN_3:  val = v3;
      default: val = 0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/vending_timeout_cnt.sv
// Inactivity counter: expire_o fires on the enabled cycle where the count
// has reached TIMEOUT-1. TIMEOUT of 0 means the counter never expires.
module vending_timeout_cnt #(
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign expire_o = (TIMEOUT != 0) && en_i && (count_q == LAST);

  // Clear wins over counting; expiry also restarts the count so it never overruns LAST.
  always_comb begin
    count_d = count_q;
    if (clr_i || expire_o) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/vending_change_ctrl.sv
// Multi-coin vending controller: accumulates credit, vends at PRICE, pays
// change one CHG_UNIT per cycle, and refunds on cancel or inactivity.
module vending_change_ctrl
  import vending_pkg::*;
#(
  parameter int unsigned PRICE    = 15,
  parameter int unsigned VAL1     = 5,
  parameter int unsigned VAL2     = 10,
  parameter int unsigned VAL3     = 25,
  parameter int unsigned CHG_UNIT = 5,
  parameter int unsigned CREDIT_W = 8,
  parameter int unsigned TIMEOUT  = 1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          coin,
  input  logic                cancel,
  output logic                pr_en,
  output logic                chg_en,
  output logic                coin_rej,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
);

  localparam int unsigned SUM_W   = CREDIT_W + 1;
  localparam int unsigned MAX_VAL = (VAL1 > VAL2) ? ((VAL1 > VAL3) ? VAL1 : VAL3)
                                                  : ((VAL2 > VAL3) ? VAL2 : VAL3);
  localparam logic [SUM_W-1:0]    PRICE_S = SUM_W'(PRICE);
  localparam logic [CREDIT_W-1:0] UNIT_C  = CREDIT_W'(CHG_UNIT);

  // Change is paid in whole units, so every amount must divide evenly.
  if (CHG_UNIT == 0 || (PRICE % CHG_UNIT) != 0 || (VAL1 % CHG_UNIT) != 0 ||
      (VAL2 % CHG_UNIT) != 0 || (VAL3 % CHG_UNIT) != 0) begin : g_bad_unit
    $error("vending_change_ctrl: PRICE and coin values must be multiples of CHG_UNIT");
  end

  // The largest credit ever held is one short of a vend plus the biggest coin.
  if ((PRICE - 1 + MAX_VAL) >= (1 << CREDIT_W)) begin : g_bad_width
    $error("vending_change_ctrl: CREDIT_W too small for PRICE-1+max coin value");
  end

  vend_state_e          state_q, state_d;
  logic [CREDIT_W-1:0]  credit_q, credit_d;
  logic                 coin_rej_q, coin_rej_d;

  logic [SUM_W-1:0]     coinVal;
  logic [SUM_W-1:0]     sum;
  logic                 coinPresent;
  logic                 acceptWindow;
  logic                 coinAccepted;
  logic                 timerClr;
  logic                 timerEn;
  logic                 timeoutExpire;

  assign coinVal      = SUM_W'(coin_value(coin, VAL1, VAL2, VAL3));
  assign sum          = {1'b0, credit_q} + coinVal;
  assign coinPresent  = (coin != COIN_NONE);
  assign acceptWindow = (state_q == IDLE) || (state_q == COLLECT);
  assign coinAccepted = acceptWindow && coinPresent;

  // The timer only runs while a partial credit sits idle in COLLECT.
  assign timerEn  = (state_q == COLLECT) && !coinPresent;
  assign timerClr = (state_q != COLLECT) || coinPresent;

  vending_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (timerClr),
    .en_i     (timerEn),
    .expire_o (timeoutExpire)
  );

  // Next-state and credit datapath; cancel on a coin edge beats a vend.
  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    coin_rej_d = !acceptWindow && coinPresent;
    case (state_q)
      IDLE, COLLECT: begin
        if (coinAccepted) begin
          if (cancel) begin
            credit_d = sum[CREDIT_W-1:0];
            state_d  = CHANGE;
          end else if (sum >= PRICE_S) begin
            credit_d = CREDIT_W'(sum - PRICE_S);
            state_d  = VEND;
          end else begin
            credit_d = sum[CREDIT_W-1:0];
            state_d  = COLLECT;
          end
        end else if ((state_q == COLLECT) && (cancel || timeoutExpire)) begin
          state_d = CHANGE;
        end
      end
      VEND: begin
        state_d = (credit_q != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        if (credit_q <= UNIT_C) begin
          credit_d = '0;
          state_d  = IDLE;
        end else begin
          credit_d = credit_q - UNIT_C;
        end
      end
      default: begin
        credit_d = '0;
        state_d  = IDLE;
      end
    endcase
  end

  // State, credit and coin-reject registers; reset abandons any change in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      credit_q   <= '0;
      coin_rej_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      coin_rej_q <= coin_rej_d;
    end
  end

  assign pr_en    = (state_q == VEND);
  assign chg_en   = (state_q == CHANGE);
  assign busy     = (state_q == VEND) || (state_q == CHANGE);
  assign coin_rej = coin_rej_q;
  assign credit   = credit_q;

  // Paying change from zero credit would mean the datapath has been corrupted.
  a_change_nonzero : assert property (@(posedge clk) disable iff (reset)
                                      (state_q != CHANGE) || (credit_q != '0));

endmodule

// File: tb/tb_vending_change_ctrl.sv
// Self-checking bench for vending_change_ctrl with a cycle-level credit model.
module tb_vending_change_ctrl;

  localparam int TO    = 1000;
  localparam int PRICE = 15;
  localparam int UNIT  = 5;

  logic       clk;
  logic       reset;
  logic [1:0] coin;
  logic       cancel;
  logic       prEn, chgEn, coinRej, busy;
  logic [7:0] credit;

  logic [1:0] coin0;
  logic       cancel0;
  logic       prEn0, chgEn0, coinRej0, busy0;
  logic [7:0] credit0;

  int testsRun;
  int testsFailed;
  int prSeen, chgSeen, rejSeen;

  int mCredit;
  bit mVend;
  bit mPay;
  bit mRej;
  int mQuiet;

  vending_change_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .coin     (coin),
    .cancel   (cancel),
    .pr_en    (prEn),
    .chg_en   (chgEn),
    .coin_rej (coinRej),
    .busy     (busy),
    .credit   (credit)
  );

  vending_change_ctrl #(.TIMEOUT(0)) dutNoTimeout (
    .clk      (clk),
    .reset    (reset),
    .coin     (coin0),
    .cancel   (cancel0),
    .pr_en    (prEn0),
    .chg_en   (chgEn0),
    .coin_rej (coinRej0),
    .busy     (busy0),
    .credit   (credit0)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int coinWorth(input logic [1:0] c);
    int w;
    w = (c == 2'b01) ? 5 : (c == 2'b10) ? 10 : (c == 2'b11) ? 25 : 0;
    return w;
  endfunction

  // Reference behaviour: one rising edge with the given coin/cancel inputs.
  task automatic modelEdge(input logic [1:0] c, input logic k);
    int sum;
    mRej = (mVend || mPay) && (c != 2'b00);
    if (mVend) begin
      mVend = 0;
      mPay  = (mCredit != 0);
    end else if (mPay) begin
      mCredit = mCredit - UNIT;
      if (mCredit == 0) mPay = 0;
    end else if (c != 2'b00) begin
      sum    = mCredit + coinWorth(c);
      mQuiet = 0;
      if (k) begin
        mCredit = sum;
        mPay    = 1;
      end else if (sum >= PRICE) begin
        mCredit = sum - PRICE;
        mVend   = 1;
      end else begin
        mCredit = sum;
      end
    end else if (mCredit != 0) begin
      if (k || (mQuiet == TO - 1)) mPay = 1;
      else mQuiet++;
    end
    if (mVend || mPay || mCredit == 0) mQuiet = 0;
  endtask

  task automatic modelReset();
    mCredit = 0;
    mVend   = 0;
    mPay    = 0;
    mRej    = 0;
    mQuiet  = 0;
  endtask

  // Compare every output of the main DUT against the model and tally pulses seen.
  task automatic checkDut();
    checkOutput("pr_en",    32'(prEn),    32'(mVend));
    checkOutput("chg_en",   32'(chgEn),   32'(mPay));
    checkOutput("busy",     32'(busy),    32'(mVend || mPay));
    checkOutput("coin_rej", 32'(coinRej), 32'(mRej));
    checkOutput("credit",   32'(credit),  32'(mCredit));
    if (prEn === 1'b1) prSeen++;
    if (chgEn === 1'b1) chgSeen++;
    if (coinRej === 1'b1) rejSeen++;
  endtask

  // Drive one cycle of inputs, advance the model at the edge, check at the falling edge.
  task automatic applyStimulus(input logic [1:0] c, input logic k);
    coin   = c;
    cancel = k;
    @(posedge clk);
    modelEdge(c, k);
    @(negedge clk);
    checkDut();
  endtask

  task automatic clearSeen();
    prSeen  = 0;
    chgSeen = 0;
    rejSeen = 0;
  endtask

  // Idle the inputs until the model says the transaction is over (bounded).
  task automatic runUntilIdle(input string tag);
    int n;
    n = 0;
    while ((mVend || mPay) && n < 20) begin
      applyStimulus(2'b00, 1'b0);
      n++;
    end
    checkOutput({tag, "_settled"}, 32'(busy), 32'(0));
  endtask

  initial begin
    int firstChg;
    int k;
    logic [1:0] c;
    logic       kc;

    testsRun    = 0;
    testsFailed = 0;
    clearSeen();
    modelReset();
    reset   = 1'b1;
    coin    = 2'b00;
    cancel  = 1'b0;
    coin0   = 2'b00;
    cancel0 = 1'b0;

    repeat (2) @(negedge clk);
    checkDut();
    checkOutput("rst_credit0", 32'(credit0), 32'(0));
    reset = 1'b0;
    clearSeen();

    // 10 then 5: exact price, no change.
    applyStimulus(2'b10, 1'b0);
    checkOutput("s1_credit10", 32'(credit), 32'(10));
    applyStimulus(2'b01, 1'b0);
    runUntilIdle("s1");
    checkOutput("s1_pr_count",  32'(prSeen),  32'(1));
    checkOutput("s1_chg_count", 32'(chgSeen), 32'(0));

    // 25: vend then two change pulses.
    clearSeen();
    applyStimulus(2'b11, 1'b0);
    runUntilIdle("s2");
    checkOutput("s2_pr_count",  32'(prSeen),  32'(1));
    checkOutput("s2_chg_count", 32'(chgSeen), 32'(2));

    // 10 + 10: vend with 5 change.
    clearSeen();
    applyStimulus(2'b10, 1'b0);
    applyStimulus(2'b10, 1'b0);
    checkOutput("s3_credit5", 32'(credit), 32'(5));
    runUntilIdle("s3");
    checkOutput("s3_pr_count",  32'(prSeen),  32'(1));
    checkOutput("s3_chg_count", 32'(chgSeen), 32'(1));

    // 5, wait, cancel: refund only.
    clearSeen();
    applyStimulus(2'b01, 1'b0);
    applyStimulus(2'b00, 1'b0);
    applyStimulus(2'b00, 1'b0);
    applyStimulus(2'b00, 1'b1);
    runUntilIdle("s4a");
    checkOutput("s4a_pr_count",  32'(prSeen),  32'(0));
    checkOutput("s4a_chg_count", 32'(chgSeen), 32'(1));

    // 5 then 10 with cancel on the same edge: cancel beats vend.
    clearSeen();
    applyStimulus(2'b01, 1'b0);
    applyStimulus(2'b10, 1'b1);
    runUntilIdle("s4b");
    checkOutput("s4b_pr_count",  32'(prSeen),  32'(0));
    checkOutput("s4b_chg_count", 32'(chgSeen), 32'(3));

    // Inactivity refund exactly TO cycles after the coin edge.
    clearSeen();
    firstChg = -1;
    applyStimulus(2'b01, 1'b0);
    k = 0;
    while (k < TO + 10 && !(chgSeen > 0 && !(mVend || mPay))) begin
      k++;
      applyStimulus(2'b00, 1'b0);
      if (chgEn === 1'b1 && firstChg < 0) firstChg = k;
    end
    checkOutput("s5_timeout_cycle", 32'(firstChg), 32'(TO));
    checkOutput("s5_chg_count",     32'(chgSeen),  32'(1));
    checkOutput("s5_pr_count",      32'(prSeen),   32'(0));

    // Coin during VEND is rejected; change still completes.
    clearSeen();
    applyStimulus(2'b11, 1'b0);
    applyStimulus(2'b01, 1'b0);
    runUntilIdle("s6");
    checkOutput("s6_rej_count", 32'(rejSeen), 32'(1));
    checkOutput("s6_chg_count", 32'(chgSeen), 32'(2));

    // Async reset in the first change cycle.
    applyStimulus(2'b11, 1'b0);
    applyStimulus(2'b00, 1'b0);
    checkOutput("s7_in_change", 32'(chgEn), 32'(1));
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput("s7_rst_pr_en",  32'(prEn),    32'(0));
    checkOutput("s7_rst_chg_en", 32'(chgEn),   32'(0));
    checkOutput("s7_rst_busy",   32'(busy),    32'(0));
    checkOutput("s7_rst_rej",    32'(coinRej), 32'(0));
    checkOutput("s7_rst_credit", 32'(credit),  32'(0));
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(2'b00, 1'b0);

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      c  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      kc = ($urandom_range(0, 15) == 0);
      applyStimulus(c, kc);
    end
    runUntilIdle("rand");

    // TIMEOUT=0 instance holds its credit indefinitely.
    clearSeen();
    coin0 = 2'b01;
    @(negedge clk);
    coin0 = 2'b00;
    for (int i = 0; i < 1300; i++) begin
      @(negedge clk);
      if (chgEn0 === 1'b1) chgSeen++;
    end
    checkOutput("s8_hold_chg_count", 32'(chgSeen), 32'(0));
    checkOutput("s8_hold_credit",    32'(credit0), 32'(5));
    checkOutput("s8_hold_busy",      32'(busy0),   32'(0));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
